// File: rtl/uart_cmd_ctrl.sv
// UART command-frame controller: parses SYNC/HDR/payload/CHK frames
// and commits good payloads into a 16 x 8 register file.
module uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_PAY    = 3'd2;
  localparam logic [2:0] S_CHK    = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  localparam logic [15:0] GAP_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic        rx_valid_q;
  logic        ev;
  logic [3:0]  base;
  logic [3:0]  len_m1;
  logic [3:0]  cnt;
  logic [7:0]  chk;
  logic [15:0] gap;
  logic [7:0]  regs  [16];
  logic [7:0]  stage [16];

  logic in_frame;
  logic timeout;
  logic last;
  logic chk_fail;
  logic commit_done;

  assign ev       = rx_valid & ~rx_valid_q;
  assign in_frame = (state == S_HDR) | (state == S_PAY) | (state == S_CHK);
  assign timeout  = in_frame & ~ev & (gap == GAP_LAST);
  assign last     = (cnt == len_m1);

  assign chk_fail    = (state == S_CHK) & ev & (chk != rx_data);
  assign commit_done = (state == S_COMMIT) & last;

  assign busy    = (state != S_IDLE);
  assign rd_data = regs[rd_addr];

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (ev && rx_data == SYNC_BYTE)
          state_nxt = S_HDR;
      end
      S_HDR: begin
        if (ev)
          state_nxt = S_PAY;
        else if (timeout)
          state_nxt = S_IDLE;
      end
      S_PAY: begin
        if (ev && last)
          state_nxt = S_CHK;
        else if (timeout)
          state_nxt = S_IDLE;
      end
      S_CHK: begin
        if (ev)
          state_nxt = (chk == rx_data) ? S_COMMIT : S_IDLE;
        else if (timeout)
          state_nxt = S_IDLE;
      end
      S_COMMIT: begin
        if (last)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Held high across reset so a level already up at release is not a byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rx_valid_q <= 1'b1;
    else
      rx_valid_q <= rx_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      gap   <= '0;
    end else begin
      state <= state_nxt;
      if (ev || state_nxt != state)
        gap <= '0;
      else if (in_frame)
        gap <= gap + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base   <= '0;
      len_m1 <= '0;
      cnt    <= '0;
      chk    <= '0;
    end else begin
      unique case (state)
        S_HDR: begin
          if (ev) begin
            base   <= rx_data[3:0];
            len_m1 <= rx_data[7:4];
            chk    <= rx_data;
            cnt    <= '0;
          end
        end
        S_PAY: begin
          if (ev) begin
            chk <= chk ^ rx_data;
            cnt <= cnt + 4'd1;
          end
        end
        S_CHK: begin
          if (ev)
            cnt <= '0;
        end
        S_COMMIT: cnt <= cnt + 4'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++)
        stage[i] <= '0;
    end else if (state == S_PAY && ev) begin
      stage[cnt] <= rx_data;
    end
  end

  // Only COMMIT writes here, so an aborted frame leaves the file intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++)
        regs[i] <= '0;
    end else if (state == S_COMMIT) begin
      regs[base + cnt] <= stage[cnt];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      frame_ok  <= commit_done;
      frame_err <= chk_fail | timeout;
      if (commit_done)
        err_code <= 2'd0;
      else if (chk_fail)
        err_code <= 2'd1;
      else if (timeout)
        err_code <= 2'd2;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: frame pulses are queued at
// stimulus time and checked by an independent monitor.
module tb_uart_cmd_ctrl;

  localparam int GAP = 24;

  typedef struct packed {
    logic       ok;
    logic [1:0] code;
  } exp_t;

  typedef logic [7:0] bq_t [$];

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];
  logic [7:0] model [16];

  uart_cmd_ctrl #(
    .TIMEOUT_CYCLES(64),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy(busy),
    .frame_ok(frame_ok),
    .frame_err(frame_err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && (frame_ok || frame_err)) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {30'd0, frame_ok, frame_err}, 0);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", {frame_ok, frame_err}, {e.ok, ~e.ok});
          chk("pulse_err_code", err_code, e.code);
          chk("pulse_busy", busy, 0);
        end
      end
    end
  end

  task automatic pulse_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    pulse_byte(b);
    repeat (GAP) @(posedge clk);
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      chk(name, rd_data, model[i]);
    end
  endtask

  task automatic send_frame(input bq_t bytes, input logic ok,
                            input logic [1:0] code, input string name);
    logic [3:0] a;
    sb.push_back('{ok: ok, code: code});
    foreach (bytes[i])
      send_byte(bytes[i]);
    if (ok) begin
      a = bytes[1][3:0];
      for (int i = 0; i <= int'(bytes[1][7:4]); i++)
        model[4'(a + 4'(i))] = bytes[2 + i];
    end
    chk({name, "_pulse_seen"}, sb.size(), 0);
    chk({name, "_err_code"}, err_code, code);
    check_regs({name, "_regs"});
  endtask

  initial begin
    bq_t f;
    int  hit;
    for (int i = 0; i < 16; i++)
      model[i] = 8'h00;
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    rd_addr  = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_frame_ok", frame_ok, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_err_code", err_code, 0);
    check_regs("reset_regs");
    repeat (5) @(posedge clk);
    #1 chk("high_at_release_no_event", busy, 0);

    f = '{8'hA5, 8'h12, 8'h11, 8'h22, 8'h21};
    send_frame(f, 1'b1, 2'd0, "write2");

    f = '{8'hA5, 8'h12, 8'h33, 8'h44, 8'h20};
    send_frame(f, 1'b0, 2'd1, "bad_chk");
    repeat (10) @(posedge clk);
    #1 chk("err_code_holds", err_code, 1);

    f = '{8'hA5, 8'hFE};
    for (int i = 0; i < 16; i++)
      f.push_back(8'(i));
    f.push_back(8'hFE);
    send_frame(f, 1'b1, 2'd0, "wrap");

    sb.push_back('{ok: 1'b0, code: 2'd2});
    send_byte(8'hA5);
    pulse_byte(8'h30);
    @(posedge clk);
    hit = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (frame_err) begin
        hit = i;
        break;
      end
    end
    chk("timeout_latency", hit, 64);
    chk("timeout_busy", busy, 0);
    chk("timeout_err_code", err_code, 2);
    repeat (4) @(posedge clk);
    chk("timeout_pulse_seen", sb.size(), 0);
    check_regs("timeout_regs");

    f = '{8'hA5, 8'h05, 8'h77, 8'h72};
    send_frame(f, 1'b1, 2'd0, "after_timeout");

    send_byte(8'h00);
    send_byte(8'h5A);
    f = '{8'hA5, 8'h17, 8'hA5, 8'h3C, 8'h8E};
    send_frame(f, 1'b1, 2'd0, "noise");

    for (int i = 0; i < 16; i++)
      model[i] = 8'h00;
    send_byte(8'hA5);
    send_byte(8'hF0);
    for (int i = 0; i < 16; i++)
      send_byte(8'h80 + 8'(i));
    pulse_byte(8'hF0);
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 chk("commit_busy_before_rst", busy, 1);
    rst = 1'b1;
    #1 chk("rst_commit_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_regs("rst_commit_regs");
    repeat (20) @(posedge clk);
    #1;
    chk("rst_commit_idle", busy, 0);
    chk("rst_commit_err_code", err_code, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command-frame controller that sits directly behind the UART receiver and sequences its byte stream into register writes. It detects each new received byte, parses SYNC/HDR/payload/CHK frames, and stages the payload. After a good checksum it commits the payload into an internal 16 x 8-bit register file, one register per cycle. Downstream logic reads the register file through a combinational read port.

## Interface
- TIMEOUT_CYCLES, 4096: maximum idle gap between bytes inside a frame, in clk cycles; legal range 1..65535.
- SYNC_BYTE, 8'hA5: frame start marker.

- clk  input  1  system clock, same clock as the receiver.
- rst  input  1  reset; asynchronous and active-high.
- rx_valid  input  1  receiver data_valid level; drops when a start bit is seen, rises when a byte completes.
- rx_data  input  8  receiver byte; stable while rx_valid is high.
- rd_addr  input  4  register-file read address.
- rd_data  output  8  register[rd_addr], combinational.
- busy  output  1  high in any state other than IDLE.
- frame_ok  output  1  one-cycle pulse when a frame has been committed.
- frame_err  output  1  one-cycle pulse when a frame is aborted.
- err_code  output  2  cause of the last abort: 0 none, 1 checksum, 2 timeout; holds until the next frame_ok or frame_err.

## Operation
- Byte event:
  - rx_valid_q is a registered copy of rx_valid.
  - An event fires when rx_valid & ~rx_valid_q.
  - rx_valid_q resets to 1, so a level that is already high at reset release is not counted as a byte.
- Frame format, in order:
  - SYNC_BYTE.
  - HDR: [3:0] start address A, [7:4] length-1 (N = HDR[7:4]+1, range 1..16).
  - N payload bytes.
  - CHK.
- Checksum: HDR XOR all payload bytes, 8-bit. The frame is good when the result equals CHK.
- States:
  - IDLE: on an event with rx_data==SYNC_BYTE go to HDR. Any other byte is dropped silently.
  - HDR: on an event latch A and N, set chk = rx_data and cnt = 0, go to PAYLOAD.
  - PAYLOAD: on an event write staging[cnt] = rx_data, chk ^= rx_data, cnt++. After byte N go to CHECK.
  - CHECK: on an event compare. On match go to COMMIT with cnt = 0. On mismatch pulse frame_err, set err_code = 1, go to IDLE.
  - COMMIT: each cycle write reg[(A+cnt) mod 16] = staging[cnt] and cnt++. After N writes pulse frame_ok, set err_code = 0, go to IDLE.
- Timeout:
  - A gap counter clears on every event and on every state change.
  - It increments in HDR, PAYLOAD and CHECK.
  - When it reaches TIMEOUT_CYCLES: pulse frame_err, set err_code = 2, go to IDLE. Staging data is discarded and the registers are untouched.
- Address wrap: A+cnt is computed in 4 bits, so writes wrap from register 15 to register 0.
- A SYNC_BYTE value appearing inside HDR, PAYLOAD or CHECK is ordinary data and does not resync.
- Events during COMMIT are ignored.
  - This cannot occur at 16x oversampling, because bytes are at least 150 cycles apart and COMMIT lasts at most 16 cycles.
- A bad frame never modifies the register file.
  - Partial commits are impossible, because the register file is written only in COMMIT.

## Timing
- Reset values:
  - State IDLE; busy, frame_ok, frame_err = 0; err_code = 0.
  - All registers = 8'h00; staging, cnt, chk and the gap counter = 0.
- Reset asserted mid-frame or mid-commit returns to IDLE immediately. Registers clear to 0, including any half-committed frame.
- Event detection: rx_valid rises at edge k, so the event is seen in cycle k and the state or data is updated at edge k+1.
- COMMIT latency:
  - The CHK event is seen in cycle k; COMMIT starts at edge k+1.
  - Writes occur at edges k+2 .. k+1+N.
  - frame_ok is high for the single cycle after the last write. busy falls in that same cycle.
- rd_data reflects a register write in the cycle after that write's edge.
- Timeout fires exactly TIMEOUT_CYCLES cycles after the last event or state entry. frame_err is high for one cycle and the state is IDLE in that same cycle.

## Test plan
- Write 2 registers: A5, 12, 11, 22, CHK=12^11^22=21 → frame_ok once; reg2=11, reg3=22; all others stay 00; err_code=0.
- Bad checksum: A5, 12, 11, 22, CHK 20 → frame_err pulse, err_code=1, all registers unchanged.
- Wrap: A5, FE (N=16, A=14), payload 00..0F, correct CHK → reg14=00, reg15=01, reg0=02 … reg13=0F.
- Timeout: with TIMEOUT_CYCLES=64, send A5, 30 and then stop → frame_err 64 cycles after the HDR event, err_code=2, busy low; a following good frame commits normally.
- Noise and reset: bytes 00, 5A, A5 before a good frame → only the frame after the A5 commits, and the data byte A5 inside the payload is stored. Also hold rx_valid high through reset release → no event. Assert rst during COMMIT → registers read 00 and state is IDLE.
